// File: rtl/digit_disp_pkg.sv
// Shared types and segment constants for the digit history display.
// Segment vectors are ordered {g,f,e,d,c,b,a}. They are active-low, so a 0 bit lights that segment.
package digit_disp_pkg;

  typedef logic [3:0] digit_t;
  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };
  localparam seg7_t SEG_DASH  = 7'h3F;
  localparam seg7_t SEG_BLANK = 7'h7F;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder. The output is active-low.
// Ports:
//   digit : input value, 0..15
//   seg   : segments {g,f,e,d,c,b,a}. Values above 9 show a dash.
module bcd_to_seg7
  import digit_disp_pkg::*;
(
  input  digit_t digit,
  output seg7_t  seg
);

  always_comb begin
    seg = SEG_DASH;
    case (digit)
      4'd0:    seg = SEG_DIGIT[0];
      4'd1:    seg = SEG_DIGIT[1];
      4'd2:    seg = SEG_DIGIT[2];
      4'd3:    seg = SEG_DIGIT[3];
      4'd4:    seg = SEG_DIGIT[4];
      4'd5:    seg = SEG_DIGIT[5];
      4'd6:    seg = SEG_DIGIT[6];
      4'd7:    seg = SEG_DIGIT[7];
      4'd8:    seg = SEG_DIGIT[8];
      4'd9:    seg = SEG_DIGIT[9];
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/digit_history_display.sv
// Captures each changed digit from an upstream mod-10 counter into a newest-first history.
// It scans that history onto a multiplexed, active-low 7-segment display.
// Ports:
//   clk, rst   : clock and asynchronous active-high reset
//   count      : digit from the upstream counter
//   capture_en : enables capture of changed digits
//   an         : active-low position enables (registered)
//   seg        : active-low segments {g,f,e,d,c,b,a} (registered)
//   dp         : active-low decimal point, lit on the newest digit (registered)
//   wrap       : one-cycle pulse on a captured 9->0 transition (registered)
//   fill_count : number of valid history entries, saturating at NUM_DIGITS
module digit_history_display
  import digit_disp_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned SCAN_DIV    = 4,
  parameter bit          BLANK_EMPTY = 1'b1,
  localparam int unsigned FillW      = $clog2(NUM_DIGITS + 1),
  localparam int unsigned SlotW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int unsigned PresW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            count,
  input  logic                  capture_en,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  wrap,
  output logic [FillW-1:0]      fill_count
);

  digit_t                  prev_q;
  digit_t                  hist_q [NUM_DIGITS];
  digit_t                  hist_d [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic [FillW-1:0]        fill_q, fill_d;
  logic [PresW-1:0]        presc_q, presc_d;
  logic [SlotW-1:0]        slot_q, slot_d;
  logic                    capture;
  logic                    wrap_d;
  logic [NUM_DIGITS-1:0]   an_d;
  seg7_t                   seg_d;
  logic                    dp_d;
  digit_t                  cur_digit;
  seg7_t                   dec_seg;

  assign capture   = capture_en && (count != prev_q);
  assign cur_digit = hist_q[slot_q];

  bcd_to_seg7 u_dec (
    .digit (cur_digit),
    .seg   (dec_seg)
  );

  // History shift and fill tracking
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      hist_d[i] = hist_q[i];
    end
    valid_d = valid_q;
    fill_d  = fill_q;
    wrap_d  = 1'b0;
    if (capture) begin
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
        hist_d[i]  = hist_q[i-1];
        valid_d[i] = valid_q[i-1];
      end
      hist_d[0]  = count;
      valid_d[0] = 1'b1;
      if (fill_q < FillW'(NUM_DIGITS)) begin
        fill_d = fill_q + FillW'(1);
      end
      wrap_d = (prev_q == 4'd9) && (count == 4'd0);
    end
  end

  // Scan prescaler and slot selection
  always_comb begin
    presc_d = presc_q + PresW'(1);
    slot_d  = slot_q;
    if (presc_q == PresW'(SCAN_DIV - 1)) begin
      presc_d = '0;
      if (slot_q == SlotW'(NUM_DIGITS - 1)) begin
        slot_d = '0;
      end else begin
        slot_d = slot_q + SlotW'(1);
      end
    end
  end

  // Display decode from pre-capture state. A new digit therefore shows one edge later.
  always_comb begin
    an_d         = '1;
    an_d[slot_q] = 1'b0;
    seg_d        = dec_seg;
    if (BLANK_EMPTY && !valid_q[slot_q]) begin
      seg_d = SEG_BLANK;
    end
    dp_d = !((slot_q == '0) && (fill_q != '0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q  <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        hist_q[i] <= '0;
      end
      valid_q <= '0;
      fill_q  <= '0;
      presc_q <= '0;
      slot_q  <= '0;
      wrap    <= 1'b0;
      an      <= '1;
      seg     <= SEG_BLANK;
      dp      <= 1'b1;
    end else begin
      prev_q  <= count;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        hist_q[i] <= hist_d[i];
      end
      valid_q <= valid_d;
      fill_q  <= fill_d;
      presc_q <= presc_d;
      slot_q  <= slot_d;
      wrap    <= wrap_d;
      an      <= an_d;
      seg     <= seg_d;
      dp      <= dp_d;
    end
  end

  assign fill_count = fill_q;

endmodule

// File: tb/tb_digit_history_display.sv
// Randomized self-checking bench for digit_history_display.
// The reference model keeps the history as a newest-first queue.
// It derives the lit position from the number of edges since reset.
module tb_digit_history_display;

  localparam int unsigned N = 4;
  localparam int unsigned D = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   count;
  logic         capture_en;
  logic [N-1:0] an;
  logic [6:0]   seg;
  logic         dp;
  logic         wrap;
  logic [2:0]   fill_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int           hist_m [$];
  int           prev_m;
  int           k_m;
  logic [N-1:0] exp_an;
  logic [6:0]   exp_seg;
  logic         exp_dp;
  logic         exp_wrap;
  int           exp_fill;

  always #5 clk = ~clk;

  digit_history_display #(
    .NUM_DIGITS  (N),
    .SCAN_DIV    (D),
    .BLANK_EMPTY (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .count      (count),
    .capture_en (capture_en),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .wrap       (wrap),
    .fill_count (fill_count)
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  function automatic void model_reset();
    hist_m.delete();
    prev_m   = 0;
    k_m      = 0;
    exp_an   = '1;
    exp_seg  = 7'h7F;
    exp_dp   = 1'b1;
    exp_wrap = 1'b0;
    exp_fill = 0;
  endfunction

  // One rising edge. The display reflects the state before the edge.
  function automatic void model_step(input int c, input bit e);
    int  slot;
    bit  cap;
    slot    = (k_m / D) % N;
    exp_an  = '1;
    exp_an[slot] = 1'b0;
    exp_seg = (slot < hist_m.size()) ? seg_of(hist_m[slot]) : 7'h7F;
    exp_dp  = !(slot == 0 && hist_m.size() > 0);
    cap      = e && (c != prev_m);
    exp_wrap = cap && prev_m == 9 && c == 0;
    if (cap) begin
      hist_m.push_front(c);
      if (hist_m.size() > N) void'(hist_m.pop_back());
    end
    exp_fill = hist_m.size();
    prev_m   = c;
    k_m++;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".an"},   an,         exp_an);
    check({tag, ".seg"},  seg,        exp_seg);
    check({tag, ".dp"},   dp,         exp_dp);
    check({tag, ".wrap"}, wrap,       exp_wrap);
    check({tag, ".fill"}, fill_count, exp_fill);
  endtask

  // Called at a negedge: drive, take the edge, update the model, compare at the next negedge.
  task automatic cycle(input string tag, input int c, input bit e);
    count      = 4'(c);
    capture_en = e;
    @(posedge clk);
    model_step(c, e);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".an"},   an,         {N{1'b1}});
    check({tag, ".seg"},  seg,        7'h7F);
    check({tag, ".dp"},   dp,         1'b1);
    check({tag, ".wrap"}, wrap,       1'b0);
    check({tag, ".fill"}, fill_count, 0);
  endtask

  initial begin
    bit found;
    rst        = 1'b1;
    count      = 4'd0;
    capture_en = 1'b0;
    model_reset();
    #100;
    @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;

    // Empty scan: positions cycle while segments stay blank
    for (int i = 0; i < 2 * N * D; i++) cycle("empty_scan", 0, 1'b0);

    // History fill 0..9
    for (int v = 0; v < 10; v++) cycle("fill", v, 1'b1);
    for (int i = 0; i < N * D; i++) cycle("fill_hold", 9, 1'b1);

    // Wrap gating: captured, then not captured
    cycle("wrap_en", 8, 1'b1);
    cycle("wrap_en", 9, 1'b1);
    cycle("wrap_en", 0, 1'b1);
    cycle("wrap_en_after", 0, 1'b1);
    cycle("wrap_dis", 8, 1'b0);
    cycle("wrap_dis", 9, 1'b0);
    cycle("wrap_dis", 0, 1'b0);
    cycle("wrap_dis_after", 0, 1'b0);

    // Invalid digit shows a dash
    cycle("invalid", 12, 1'b1);
    for (int i = 0; i < N * D; i++) cycle("invalid_hold", 12, 1'b0);

    // Random traffic, with forced 9->0 pairs
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        cycle("rand_wrap", 9, 1'b1);
        cycle("rand_wrap", 0, $urandom_range(0, 1) == 1);
      end else if ($urandom_range(0, 3) == 0) begin
        cycle("rand_hold", prev_m, $urandom_range(0, 1) == 1);
      end else begin
        cycle("rand", $urandom_range(0, 15), $urandom_range(0, 3) != 0);
      end
    end

    // Reset mid-operation while position 2 is lit with a full history
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      cycle("pre_midrst", (prev_m + 1) % 10, 1'b1);
      if (hist_m.size() == N && exp_an == 4'b1011) found = 1'b1;
    end
    check("midrst_found", found, 1);
    #1 rst = 1'b1;
    #1 check_reset_vals("midrst_async");
    @(posedge clk);
    @(negedge clk);
    check_reset_vals("midrst_hold");
    model_reset();
    count = 4'd0;
    rst   = 1'b0;
    for (int i = 0; i < 2 * N * D; i++) begin
      cycle("post_rst", $urandom_range(0, 9), $urandom_range(0, 1) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
